// File: rtl/uart_tx_fifo.sv
// UART transmitter with a valid/ready input FIFO, configurable data width, parity and stop bits.
// Frames go out back-to-back with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 217,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [DATA_BITS-1:0]          data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [AW:0]          lvl_q;
  logic                 push, pop, load, bit_end;
  logic [DATA_BITS-1:0] head;

  state_e               st_q, st_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d, tx_q, tx_d, busy_q, busy_d;

  assign ready_o = (lvl_q != (AW+1)'(FIFO_DEPTH));
  assign push    = valid_i & ready_o;
  assign head    = mem_q[rp_q];
  assign bit_end = (cnt_q == CW'(CLK_DIV-1));

  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q] <= data_i;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      lvl_q <= lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    par_d  = par_q;
    tx_d   = tx_q;
    busy_d = busy_q;
    load   = 1'b0;
    pop    = 1'b0;
    if (st_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    case (st_q)
      IDLE:  load = (lvl_q != '0);
      START: if (bit_end) begin
        st_d  = DATA;
        tx_d  = sh_q[0];
        bit_d = '0;
      end
      DATA: if (bit_end) begin
        if (bit_q == 4'(DATA_BITS-1)) begin
          if (PARITY != 0) begin
            st_d = PAR;
            tx_d = par_q;
          end else begin
            st_d  = STOP;
            tx_d  = 1'b1;
            bit_d = '0;
          end
        end else begin
          // the shifter's LSB is always the bit on the line
          sh_d  = sh_q >> 1;
          tx_d  = sh_q[1];
          bit_d = bit_q + 4'd1;
        end
      end
      PAR: if (bit_end) begin
        st_d  = STOP;
        tx_d  = 1'b1;
        bit_d = '0;
      end
      STOP: if (bit_end) begin
        if (bit_q == 4'(STOP_BITS-1)) begin
          load = (lvl_q != '0);
          if (!load) begin
            st_d   = IDLE;
            busy_d = 1'b0;
            tx_d   = 1'b1;
          end
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: st_d = IDLE;
    endcase
    // a pop starts the next frame on the following edge, from IDLE or the last stop cycle
    if (load) begin
      pop    = 1'b1;
      sh_d   = head;
      par_d  = (^head) ^ (PARITY == 1);
      tx_d   = 1'b0;
      busy_d = 1'b1;
      st_d   = START;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign level_o = lvl_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench: two configurations driven side by side, each checked every cycle
// against a frame-position model built from the UART framing rules.
module tb_uart_tx_fifo;
  logic       CLK, RST_N;
  logic [7:0] da;
  logic [4:0] db;
  logic       va, vb;
  logic       a_rdy, a_tx, a_busy, b_rdy, b_tx, b_busy;
  logic [2:0] a_lvl;
  logic [1:0] b_lvl;

  int n_cmp = 0, n_err = 0, prob = 0;

  // config 0: CLK_DIV=4, 8 data, even parity, 2 stop, depth 4
  // config 1: CLK_DIV=3, 5 data, odd parity, 1 stop, depth 2
  int cfg_div [2] = '{4, 3};
  int cfg_db  [2] = '{8, 5};
  int cfg_par [2] = '{2, 1};
  int cfg_sb  [2] = '{2, 1};
  int cfg_dep [2] = '{4, 2};

  logic [7:0] mf  [2][8];
  int         mn  [2];
  int         pos [2];
  logic [7:0] cur [2];

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_a (
    .CLK(CLK), .RST_N(RST_N), .data_i(da), .valid_i(va), .ready_o(a_rdy),
    .tx_o(a_tx), .busy_o(a_busy), .level_o(a_lvl));

  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u_b (
    .CLK(CLK), .RST_N(RST_N), .data_i(db), .valid_i(vb), .ready_o(b_rdy),
    .tx_o(b_tx), .busy_o(b_busy), .level_o(b_lvl));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic int flen(input int id);
    return cfg_div[id] * (1 + cfg_db[id] + ((cfg_par[id] != 0) ? 1 : 0) + cfg_sb[id]);
  endfunction

  // expected line level from the bit slot the current frame is in
  function automatic int exp_tx(input int id);
    int b;
    logic [7:0] w;
    if (pos[id] < 0) return 1;
    b = pos[id] / cfg_div[id];
    w = cur[id] & 8'((1 << cfg_db[id]) - 1);
    if (b == 0) return 0;
    if (b <= cfg_db[id]) return int'(w[b-1]);
    if (cfg_par[id] != 0 && b == cfg_db[id] + 1)
      return int'((^w) ^ (cfg_par[id] == 1));
    return 1;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      mn[i]  = 0;
      pos[i] = -1;
    end
  endtask

  task automatic mdl_step(input int id, input logic acc, input logic [7:0] d);
    if (pos[id] >= 0) begin
      pos[id]++;
      if (pos[id] == flen(id)) pos[id] = -1;
    end
    if (pos[id] < 0 && mn[id] > 0) begin
      cur[id] = mf[id][0];
      for (int i = 0; i < 7; i++) mf[id][i] = mf[id][i+1];
      mn[id]--;
      pos[id] = 0;
    end
    if (acc) begin
      mf[id][mn[id]] = d;
      mn[id]++;
    end
  endtask

  task automatic check_all();
    chk("a_tx",   int'(a_tx),   exp_tx(0));
    chk("a_busy", int'(a_busy), (pos[0] >= 0) ? 1 : 0);
    chk("a_lvl",  int'(a_lvl),  mn[0]);
    chk("a_rdy",  int'(a_rdy),  (mn[0] != cfg_dep[0]) ? 1 : 0);
    chk("b_tx",   int'(b_tx),   exp_tx(1));
    chk("b_busy", int'(b_busy), (pos[1] >= 0) ? 1 : 0);
    chk("b_lvl",  int'(b_lvl),  mn[1]);
    chk("b_rdy",  int'(b_rdy),  (mn[1] != cfg_dep[1]) ? 1 : 0);
  endtask

  task automatic cyc();
    logic aa, ab;
    aa = va && (mn[0] != cfg_dep[0]);
    ab = vb && (mn[1] != cfg_dep[1]);
    @(posedge CLK);
    mdl_step(0, aa, da);
    mdl_step(1, ab, {3'b000, db});
    #1;
    check_all();
    if (!va || aa) begin
      va = ($urandom_range(99) < prob);
      da = 8'($urandom);
    end
    if (!vb || ab) begin
      vb = ($urandom_range(99) < prob);
      db = 5'($urandom);
    end
  endtask

  initial begin
    int n;
    RST_N = 1'b0;
    va = 1'b0; vb = 1'b0; da = '0; db = '0;
    mdl_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    RST_N = 1'b1;

    prob = 100; repeat (400)  cyc();
    prob = 30;  repeat (1500) cyc();
    prob = 5;   repeat (800)  cyc();

    // steer config 0 into its data bits with at least two words queued
    prob = 100;
    n = 0;
    while (!(mn[0] >= 2 && pos[0] >= 2 * cfg_div[0] && pos[0] < 8 * cfg_div[0]) && n < 500) begin
      cyc();
      n++;
    end
    chk("rst_setup_reached", (n < 500) ? 1 : 0, 1);
    #2;
    RST_N = 1'b0;
    va = 1'b0; vb = 1'b0;
    #1;
    mdl_reset();
    check_all();
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    RST_N = 1'b1;

    prob = 0;  repeat (100) cyc();
    prob = 50; repeat (800) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
